// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer: issues sequential fetches, queues returned
// words with their PCs and hands them to decode; redirects flush and restart.
module fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instruction
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] stale;
    logic [CW-1:0] inflight_nxt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   pc_mem  [DEPTH];
    logic [31:0]   ins_mem [DEPTH];

    logic [CW:0]   occupancy;
    logic          req_fire;
    logic          resp_ok;
    logic          push;
    logic          pop;
    logic [31:0]   target;

    // Credit rule: queued plus outstanding never exceeds DEPTH, so pushes can't overflow.
    assign occupancy      = {1'b0, count} + {1'b0, inflight};
    assign imem_req_valid = !reset && !redirect_valid && (occupancy < LIMIT);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_ok        = imem_resp_valid && (inflight != '0);
    assign push           = resp_ok && (stale == '0);
    assign out_valid      = (count != '0) && !redirect_valid;
    assign pop            = out_valid && out_ready;
    assign out_pc         = pc_mem[rd_ptr];
    assign out_instruction = ins_mem[rd_ptr];
    assign target         = redirect_target & 32'hFFFF_FFFC;

    always_comb begin
        inflight_nxt = inflight;
        if (req_fire)
            inflight_nxt = inflight_nxt + CW'(1);
        if (resp_ok)
            inflight_nxt = inflight_nxt - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            stale    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]  <= '0;
                ins_mem[i] <= '0;
            end
        end else begin
            inflight <= inflight_nxt;
            if (redirect_valid) begin
                // Everything still outstanding, minus this cycle's response, is discarded.
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                stale    <= inflight_nxt;
                fetch_pc <= target;
                resp_pc  <= target;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (resp_ok && (stale != '0))
                    stale <= stale - CW'(1);
                if (push) begin
                    pc_mem[wr_ptr]  <= resp_pc;
                    ins_mem[wr_ptr] <= imem_resp_data;
                    wr_ptr          <= wr_ptr + AW'(1);
                    resp_pc         <= resp_pc + 32'd4;
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule
